ahb_rr_arbiter: RTL and testbench
=================================

# ahb_rr_arbiter

Round-robin AHB arbiter and bus multiplexer that shares the single AHB-to-APB bridge slave port among up to eight AHB masters. It runs AHB2-style request/grant arbitration (HBUSREQ/HGRANT) with locked-transfer support. It drives the address phase from the current owner and the write data from the data-phase owner. Read data and responses (HRDATA, HREADY, HRESP) from the bridge are broadcast to all masters outside this block.

## Interface
Parameters:
- NUM_MASTERS, 4, number of masters; legal range 2..8.
- ADDRWIDTH, 16, address width.
- DATAWIDTH, 32, data width.

Ports:
- HCLK  input  1  AHB clock; the only clock.
- HRESETn  input  1  asynchronous, active-low reset.
- HBUSREQ  input  NUM_MASTERS  per-master bus request.
- HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
- HADDR_M  input  NUM_MASTERS*ADDRWIDTH  flattened master addresses; master i at [i*ADDRWIDTH +: ADDRWIDTH].
- HTRANS_M  input  NUM_MASTERS*2  flattened transfer types.
- HWRITE_M  input  NUM_MASTERS  write flags.
- HSIZE_M  input  NUM_MASTERS*3  transfer sizes.
- HPROT_M  input  NUM_MASTERS*4  protection.
- HWDATA_M  input  NUM_MASTERS*DATAWIDTH  write data.
- HREADY  input  1  bus ready from the bridge (HREADYOUT).
- HGRANT  output  NUM_MASTERS  one-hot grant.
- HMASTER  output  3  current address-phase owner index.
- HMASTLOCK  output  1  current address phase is locked.
- HADDR  output  ADDRWIDTH  muxed address to the bridge.
- HTRANS  output  2  muxed transfer type.
- HWRITE  output  1  muxed write flag.
- HSIZE  output  3  muxed size.
- HPROT  output  4  muxed protection.
- HWDATA  output  DATAWIDTH  muxed write data, selected by the data-phase owner.

## Operation
- Three registers:
  - grant_idx: the index driven as HGRANT.
  - HMASTER: the address-phase owner.
  - dmaster: the data-phase owner, internal.
- Arbitration runs every cycle with HREADY=1. HREADY=0 freezes all three registers.
- Hold condition: HBUSREQ[grant_idx] & HLOCK[grant_idx]. While it holds, grant_idx does not change.
- Otherwise grant_idx takes the first requesting index, searching grant_idx+1, grant_idx+2, … with wrap-around modulo NUM_MASTERS. The current holder is checked last.
- If no master requests, grant_idx is unchanged (the bus parks on the last owner).
- On each HREADY=1 edge, all of the following update together:
  - HMASTER <= grant_idx (old value).
  - HMASTLOCK <= HLOCK[grant_idx].
  - dmaster <= HMASTER.
- HADDR, HTRANS, HWRITE, HSIZE and HPROT are combinational selects of master HMASTER.
- HWDATA is a combinational select of master dmaster.
- HGRANT = one-hot of grant_idx.
- Requests and locks at indices >= NUM_MASTERS do not exist. Unused HMASTER bits are 0.
- Reset (asynchronous, on HRESETn low, including mid-transfer):
  - grant_idx=0, HMASTER=0, dmaster=0, HMASTLOCK=0.
  - HGRANT=1 (one-hot, bit 0).
  - Muxed outputs follow master 0 immediately.

## Timing
- Request-to-ownership latency with HREADY held high:
  - HBUSREQ asserted before edge N.
  - HGRANT updates after edge N.
  - HMASTER updates after edge N+1; the master's address phase is on the bus in that cycle.
  - Its HWDATA is selected after edge N+2.
- HREADY low for k cycles delays every stage by exactly k cycles.
- Locked sequence: the owner keeps HGRANT for every cycle HLOCK and HBUSREQ stay high. Grant may move at the first HREADY=1 edge after either one drops.
- Simultaneous requests: the winner is the nearest index after the current grant, so no master waits more than NUM_MASTERS-1 grant changes.
- Address and data phases of different masters overlap cycle-for-cycle; HWDATA never comes from the address-phase owner unless HMASTER equals dmaster.

## Test plan
- Reset, no requests, HREADY=1 for 10 cycles -> HGRANT=0001, HMASTER=0, HMASTLOCK=0. HADDR tracks master 0 (HADDR_M[0]=0x1234 gives HADDR=0x1234).
- Reset released, HBUSREQ=0110 held, HREADY=1 -> HGRANT sequence 0010, 0100, 0010, 0100…; HMASTER follows one cycle later (1, 2, 1, 2…).
- Master 2 with HLOCK=1 and HBUSREQ=1 for 5 cycles while HBUSREQ=1111 -> HGRANT stays 0100 and HMASTLOCK=1 for those cycles. After lock release the next grant is 1000.
- Master 3 writes 0xDEADBEEF: address phase HMASTER=3, then the grant moves to master 1 -> during the following cycle HMASTER=1 and HWDATA=0xDEADBEEF from master 3.
- HREADY=0 for 3 cycles while HBUSREQ switches from 0001 to 0010 -> HGRANT, HMASTER and HWDATA are frozen for those 3 cycles, then advance with normal latency.
- HRESETn pulsed low mid-transfer with HMASTER=2 -> HGRANT=0001, HMASTER=0 and HMASTLOCK=0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB2 request/grant arbiter with locked-transfer hold, and the
// address/data-phase bus multiplexer in front of the shared AHB-to-APB bridge.
module ahb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDRWIDTH   = 16,
    parameter int unsigned DATAWIDTH   = 32
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NUM_MASTERS-1:0]           HBUSREQ,
    input  logic [NUM_MASTERS-1:0]           HLOCK,
    input  logic [NUM_MASTERS*ADDRWIDTH-1:0] HADDR_M,
    input  logic [NUM_MASTERS*2-1:0]         HTRANS_M,
    input  logic [NUM_MASTERS-1:0]           HWRITE_M,
    input  logic [NUM_MASTERS*3-1:0]         HSIZE_M,
    input  logic [NUM_MASTERS*4-1:0]         HPROT_M,
    input  logic [NUM_MASTERS*DATAWIDTH-1:0] HWDATA_M,
    input  logic                             HREADY,
    output logic [NUM_MASTERS-1:0]           HGRANT,
    output logic [2:0]                       HMASTER,
    output logic                             HMASTLOCK,
    output logic [ADDRWIDTH-1:0]             HADDR,
    output logic [1:0]                       HTRANS,
    output logic                             HWRITE,
    output logic [2:0]                       HSIZE,
    output logic [3:0]                       HPROT,
    output logic [DATAWIDTH-1:0]             HWDATA
);

    localparam int unsigned IDXW = 3;
    localparam int unsigned MAXM = 8;

    logic [MAXM-1:0] req_ext;
    logic [MAXM-1:0] lock_ext;
    logic [IDXW-1:0] grant_idx;
    logic [IDXW-1:0] grant_nxt;
    logic [IDXW-1:0] dmaster;
    logic [IDXW:0]   cand;
    logic            found;

    // Non-existent masters read as idle so a 3-bit index is always safe.
    assign req_ext  = MAXM'(HBUSREQ);
    assign lock_ext = MAXM'(HLOCK);

    // Nearest requester after the current holder; holder itself is implicitly last.
    always_comb begin
        grant_nxt = grant_idx;
        found     = 1'b0;
        cand      = '0;
        if (!(req_ext[grant_idx] && lock_ext[grant_idx])) begin
            for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
                cand = 4'(grant_idx) + 4'(k);
                if (cand >= 4'(NUM_MASTERS)) begin
                    cand = cand - 4'(NUM_MASTERS);
                end
                if (!found && req_ext[cand[IDXW-1:0]]) begin
                    grant_nxt = cand[IDXW-1:0];
                    found     = 1'b1;
                end
            end
        end
    end

    // Grant -> address owner -> data owner pipeline, frozen while HREADY is low.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_idx <= '0;
            HMASTER   <= '0;
            HMASTLOCK <= 1'b0;
            dmaster   <= '0;
        end else if (HREADY) begin
            grant_idx <= grant_nxt;
            HMASTER   <= grant_idx;
            HMASTLOCK <= lock_ext[grant_idx];
            dmaster   <= HMASTER;
        end
    end

    always_comb begin
        HGRANT = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == 3'(i)) begin
                HGRANT[i] = 1'b1;
            end
        end
    end

    // Address-phase signals follow HMASTER, write data follows the data-phase owner.
    always_comb begin
        HADDR  = HADDR_M[ADDRWIDTH-1:0];
        HTRANS = HTRANS_M[1:0];
        HWRITE = HWRITE_M[0];
        HSIZE  = HSIZE_M[2:0];
        HPROT  = HPROT_M[3:0];
        HWDATA = HWDATA_M[DATAWIDTH-1:0];
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (HMASTER == 3'(i)) begin
                HADDR  = HADDR_M[i*ADDRWIDTH +: ADDRWIDTH];
                HTRANS = HTRANS_M[i*2 +: 2];
                HWRITE = HWRITE_M[i];
                HSIZE  = HSIZE_M[i*3 +: 3];
                HPROT  = HPROT_M[i*4 +: 4];
            end
            if (dmaster == 3'(i)) begin
                HWDATA = HWDATA_M[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: per-cycle comparison against a
// distance-based round-robin model plus directed literal expectations.
module tb_ahb_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [N-1:0]      HBUSREQ;
    logic [N-1:0]      HLOCK;
    logic [N*AW-1:0]   HADDR_M;
    logic [N*2-1:0]    HTRANS_M;
    logic [N-1:0]      HWRITE_M;
    logic [N*3-1:0]    HSIZE_M;
    logic [N*4-1:0]    HPROT_M;
    logic [N*DW-1:0]   HWDATA_M;
    logic              HREADY;
    logic [N-1:0]      HGRANT;
    logic [2:0]        HMASTER;
    logic              HMASTLOCK;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [3:0]        HPROT;
    logic [DW-1:0]     HWDATA;

    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [1:0]    trans_a [N];
    logic [2:0]    size_a  [N];
    logic [3:0]    prot_a  [N];
    logic          write_a [N];

    int checks = 0;
    int passed = 0;
    bit check_en = 1'b0;

    // Model state: grant, address owner, data owner, lock flag.
    int m_g  = 0;
    int m_hm = 0;
    int m_dm = 0;
    bit m_ml = 1'b0;

    ahb_rr_arbiter #(.NUM_MASTERS(N), .ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
        .HSIZE_M(HSIZE_M), .HPROT_M(HPROT_M), .HWDATA_M(HWDATA_M),
        .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
        .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA)
    );

    always #5 HCLK = ~HCLK;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            HADDR_M[i*AW +: AW]  = addr_a[i];
            HWDATA_M[i*DW +: DW] = wdata_a[i];
            HTRANS_M[i*2 +: 2]   = trans_a[i];
            HSIZE_M[i*3 +: 3]    = size_a[i];
            HPROT_M[i*4 +: 4]    = prot_a[i];
            HWRITE_M[i]          = write_a[i];
        end
    end

    // Winner is the requester at the smallest forward distance; the holder counts as distance N.
    function automatic int model_next(int g, logic [N-1:0] req, logic [N-1:0] lock);
        int best;
        int bestd;
        int d;
        if (req[g] && lock[g]) return g;
        best  = g;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                d = (i - g + N) % N;
                if (d == 0) d = N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_g = 0; m_hm = 0; m_dm = 0; m_ml = 1'b0;
        end else if (HREADY) begin
            m_dm = m_hm;
            m_hm = m_g;
            m_ml = HLOCK[m_g];
            m_g  = model_next(m_g, HBUSREQ, HLOCK);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge HCLK) begin
        if (check_en) begin
            chk("m_hgrant",    64'(HGRANT),    64'(1 << m_g));
            chk("m_hmaster",   64'(HMASTER),   64'(m_hm));
            chk("m_hmastlock", 64'(HMASTLOCK), 64'(m_ml));
            chk("m_haddr",     64'(HADDR),     64'(addr_a[m_hm]));
            chk("m_htrans",    64'(HTRANS),    64'(trans_a[m_hm]));
            chk("m_hwrite",    64'(HWRITE),    64'(write_a[m_hm]));
            chk("m_hsize",     64'(HSIZE),     64'(size_a[m_hm]));
            chk("m_hprot",     64'(HPROT),     64'(prot_a[m_hm]));
            chk("m_hwdata",    64'(HWDATA),    64'(wdata_a[m_dm]));
        end
    end

    task automatic step();
        @(posedge HCLK);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] vreq  [8] = '{4'b1001, 4'b1111, 4'b0101, 4'b0000, 4'b1010, 4'b0011, 4'b1100, 4'b0001};
    logic [N-1:0] vlock [8] = '{4'b0000, 4'b0010, 4'b0000, 4'b1111, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    logic         vrdy  [8] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_a[i]  = AW'(16'h1234 + i * 16'h1111);
            wdata_a[i] = (i == 3) ? 32'hDEADBEEF : DW'(32'hA000_0000 + i);
            trans_a[i] = 2'(i);
            size_a[i]  = 3'(i + 1);
            prot_a[i]  = 4'(i + 8);
            write_a[i] = 1'(i);
        end
        HRESETn = 1'b0;
        HBUSREQ = '0;
        HLOCK   = '0;
        HREADY  = 1'b1;
        step(); step();
        check_en = 1'b1;
        HRESETn  = 1'b1;

        // Idle bus parks on master 0.
        repeat (10) step();
        chk("idle_hgrant",  64'(HGRANT),    64'h1);
        chk("idle_hmaster", 64'(HMASTER),   64'h0);
        chk("idle_lock",    64'(HMASTLOCK), 64'h0);
        chk("idle_haddr",   64'(HADDR),     64'h1234);

        // Alternation between masters 1 and 2.
        HBUSREQ = 4'b0110;
        step();
        chk("rr_g1",  64'(HGRANT),  64'b0010);
        chk("rr_hm1", 64'(HMASTER), 64'd0);
        step();
        chk("rr_g2",  64'(HGRANT),  64'b0100);
        chk("rr_hm2", 64'(HMASTER), 64'd1);
        step();
        chk("rr_g3",  64'(HGRANT),  64'b0010);
        chk("rr_hm3", 64'(HMASTER), 64'd2);

        // Master 2 locks while everyone requests.
        HBUSREQ = 4'b1111;
        HLOCK   = 4'b0100;
        step();
        chk("lk_g0", 64'(HGRANT), 64'b0100);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("lk_g",    64'(HGRANT),    64'b0100);
            chk("lk_lock", 64'(HMASTLOCK), 64'h1);
        end
        HLOCK = 4'b0000;
        step();
        chk("lk_rel_g",    64'(HGRANT),    64'b1000);
        chk("lk_rel_lock", 64'(HMASTLOCK), 64'h0);

        // Master 3 write data overlaps master 1 address phase.
        HBUSREQ = 4'b1010;
        step();
        chk("wr_hm3",    64'(HMASTER), 64'd3);
        chk("wr_hwrite", 64'(HWRITE),  64'h1);
        step();
        chk("wr_hm1",    64'(HMASTER), 64'd1);
        chk("wr_hwdata", 64'(HWDATA),  64'hDEADBEEF);
        chk("wr_haddr",  64'(HADDR),   64'h2345);

        // HREADY low freezes the pipeline for three cycles.
        HBUSREQ = 4'b0001;
        repeat (3) step();
        HREADY  = 1'b0;
        HBUSREQ = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("st_g",  64'(HGRANT),  64'b0001);
            chk("st_hm", 64'(HMASTER), 64'd0);
            chk("st_wd", 64'(HWDATA),  64'hA000_0000);
        end
        HREADY = 1'b1;
        step();
        chk("st_g1",  64'(HGRANT),  64'b0010);
        chk("st_hm0", 64'(HMASTER), 64'd0);
        step();
        chk("st_hm1", 64'(HMASTER), 64'd1);
        chk("st_wd0", 64'(HWDATA),  64'hA000_0000);
        step();
        chk("st_wd1", 64'(HWDATA),  64'hA000_0001);

        // Directed mixed vectors, checked by the model only.
        for (int v = 0; v < 8; v++) begin
            HBUSREQ = vreq[v];
            HLOCK   = vlock[v];
            HREADY  = vrdy[v];
            repeat (2) step();
        end
        HREADY = 1'b1;

        // Asynchronous reset during a locked transfer of master 2.
        HBUSREQ = 4'b0010;
        HLOCK   = 4'b0000;
        repeat (3) step();
        HBUSREQ = 4'b0100;
        HLOCK   = 4'b0100;
        step(); step();
        chk("ar_pre_hm",   64'(HMASTER),   64'd2);
        chk("ar_pre_lock", 64'(HMASTLOCK), 64'h1);
        HRESETn = 1'b0;
        #1;
        chk("ar_hgrant",  64'(HGRANT),    64'h1);
        chk("ar_hmaster", 64'(HMASTER),   64'h0);
        chk("ar_lock",    64'(HMASTLOCK), 64'h0);
        chk("ar_haddr",   64'(HADDR),     64'h1234);
        step();
        HRESETn = 1'b1;
        HBUSREQ = '0;
        HLOCK   = '0;
        repeat (3) step();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
